// File: rtl/regfile_mp_if.sv
// Bus interface for regfile_mp: two combinational read ports, one write port,
// soft-clear handshake and the registered debug read port.
interface regfile_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_addr1;
   logic [DATA_W-1:0] rd_data1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rd_data2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              clr_req;
   logic              clr_busy;
   logic              clr_done;
   logic              wr_drop;
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;

   // Datapath / control side driving addresses, writes and clear requests.
   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
      input  rd_data1, rd_data2, clr_busy, clr_done, wr_drop, dbg_data
   );

   // Register file side.
   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req, dbg_addr,
      output rd_data1, rd_data2, clr_busy, clr_done, wr_drop, dbg_data
   );
endinterface

// File: rtl/regfile_mp.sv
// General-purpose register file for the MIPS datapath: two combinational read
// ports, one synchronous write port, optional hardwired zero register, a
// sequential soft-clear engine (IDLE -> SWEEP -> DONE) and a registered debug
// read port.
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write
// straight to matching read ports in the same cycle (debug port excluded).
module regfile_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_mp_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SWEEP,
      DONE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok;

   // True when the address names the hardwired zero register.
   function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
      return (ZERO_REG != 0) && (addr == '0);
   endfunction

   // A write commits only while idle and never to the zero register.
   assign wr_ok = bus.wr_en && (state == IDLE) && !is_zero(bus.wr_addr);

   // Clear FSM state register and sweep pointer.
   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            ptr <= '0;
         else if (state == SWEEP)
            ptr <= ptr + ADDR_W'(1);
      end
   end

   // Clear FSM next state and Moore status outputs.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_nxt    = state;
      bus.clr_busy = 1'b0;
      bus.clr_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.clr_req)
               state_nxt = SWEEP;
         end
         SWEEP: begin
            bus.clr_busy = 1'b1;
            if (ptr == LAST)
               state_nxt = DONE;
         end
         DONE: begin
            bus.clr_done = 1'b1;
            state_nxt    = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Register array: sweep clears one entry per cycle, otherwise idle writes commit.
   // NOTE: the array is reset explicitly because reset must leave every register at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
      end else if (state == SWEEP) begin
         regs[ptr] <= '0;
      end else if (wr_ok) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   // Flag a write that arrived while the clear engine owned the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus.wr_drop <= 1'b0;
      else
         bus.wr_drop <= bus.wr_en && (state != IDLE) && !is_zero(bus.wr_addr);
   end

   // Debug port captures pre-edge contents, never bypassed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bus.dbg_data <= '0;
      else
         bus.dbg_data <= is_zero(bus.dbg_addr) ? '0 : regs[bus.dbg_addr];
   end

   // Read port 1, with optional same-cycle write forwarding.
   always_comb begin
      bus.rd_data1 = is_zero(bus.rd_addr1) ? '0 : regs[bus.rd_addr1];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.wr_addr == bus.rd_addr1))
         bus.rd_data1 = bus.wr_data;
`else
`endif
   end

   // Read port 2, with optional same-cycle write forwarding.
   always_comb begin
      bus.rd_data2 = is_zero(bus.rd_addr2) ? '0 : regs[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (bus.wr_addr == bus.rd_addr2))
         bus.rd_data2 = bus.wr_data;
`else
`endif
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, hand-written
// clear-sweep / mid-sweep / reset-abort sequences, then randomized traffic
// checked against a behavioural model of the register file.
module tb_regfile_mp;

   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
   localparam int ZR    = 1;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   logic [DW-1:0] m_reg [DEPTH];
   int            m_phase;   // 0 idle, 1 clearing, 2 finished pulse
   int            m_ptr;
   logic          m_drop;
   logic [DW-1:0] m_dbg;

   function automatic logic [DW-1:0] m_read(input int a);
      if (ZR != 0 && a == 0) return '0;
      return m_reg[a];
   endfunction

   function automatic logic [DW-1:0] m_port(input int a);
      if (BYP && bus.wr_en && m_phase == 0 && a == int'(bus.wr_addr) && !(ZR != 0 && a == 0))
         return bus.wr_data;
      return m_read(a);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
      m_phase = 0;
      m_ptr   = 0;
      m_drop  = 1'b0;
      m_dbg   = '0;
   endtask

   task automatic model_edge();
      int wa;
      wa     = int'(bus.wr_addr);
      m_dbg  = m_read(int'(bus.dbg_addr));
      m_drop = bus.wr_en && (m_phase != 0) && !(ZR != 0 && wa == 0);
      case (m_phase)
         0: begin
            if (bus.wr_en && !(ZR != 0 && wa == 0)) m_reg[wa] = bus.wr_data;
            if (bus.clr_req) begin
               m_phase = 1;
               m_ptr   = 0;
            end
         end
         1: begin
            m_reg[m_ptr] = '0;
            if (m_ptr == DEPTH - 1) m_phase = 2;
            else m_ptr = m_ptr + 1;
         end
         default: m_phase = 0;
      endcase
   endtask

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("rd_data1", bus.rd_data1, m_port(int'(bus.rd_addr1)));
      check("rd_data2", bus.rd_data2, m_port(int'(bus.rd_addr2)));
      check("clr_busy", DW'(bus.clr_busy), DW'(m_phase == 1));
      check("clr_done", DW'(bus.clr_done), DW'(m_phase == 2));
      check("wr_drop", DW'(bus.wr_drop), DW'(m_drop));
      check("dbg_data", bus.dbg_data, m_dbg);
   endtask

   task automatic edge_step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic tick();
      @(negedge clk);
      compare_all();
      edge_step();
   endtask

   task automatic set_idle();
      bus.wr_en    = 1'b0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.clr_req  = 1'b0;
      bus.rd_addr1 = '0;
      bus.rd_addr2 = '0;
      bus.dbg_addr = '0;
   endtask

   task automatic write_reg(input int a, input logic [DW-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = AW'(a);
      bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic          wr_en;
      logic [AW-1:0] wr_addr;
      logic [DW-1:0] wr_data;
      logic [AW-1:0] rd_addr1;
      logic [AW-1:0] rd_addr2;
      logic [AW-1:0] dbg_addr;
      logic [DW-1:0] e_rd1;
      logic [DW-1:0] e_rd2;
      logic [DW-1:0] e_dbg;
      logic          e_drop;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int busy_cnt;
      int done_cnt;

      // Expected values are those visible before the vector's own clock edge.
      vecs[0] = '{1'b1, 5'd8, 32'hDEADBEEF, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0};
      vecs[1] = '{1'b0, 5'd0, 32'h0, 5'd8, 5'd9, 5'd8, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0};
      vecs[2] = '{1'b1, 5'd0, 32'h12345678, 5'd0, 5'd8, 5'd8, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[3] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0};
      vecs[4] = '{1'b1, 5'd5, 32'h55, 5'd5, 5'd5, 5'd5, BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, 32'h0, 1'b0};
      vecs[5] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 5'd5, 32'h55, 32'h55, 32'h0, 1'b0};
      vecs[6] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd8, 5'd9, 32'h55, 32'hDEADBEEF, 32'h55, 1'b0};
      vecs[7] = '{1'b1, 5'd9, 32'h1234, 5'd9, 5'd8, 5'd9, BYP ? 32'h1234 : 32'h0, 32'hDEADBEEF, 32'h0, 1'b0};
      vecs[8] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd1, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b0};

      // Reset state
      set_idle();
      model_reset();
      rst_n = 1'b0;
      #12;
      check("reset_busy", DW'(bus.clr_busy), '0);
      check("reset_done", DW'(bus.clr_done), '0);
      check("reset_drop", DW'(bus.wr_drop), '0);
      check("reset_dbg", bus.dbg_data, '0);
      check("reset_rd1", bus.rd_data1, '0);
      rst_n = 1'b1;
      edge_step();

      // Table-driven directed vectors
      for (int i = 0; i < 9; i++) begin
         bus.wr_en    = vecs[i].wr_en;
         bus.wr_addr  = vecs[i].wr_addr;
         bus.wr_data  = vecs[i].wr_data;
         bus.rd_addr1 = vecs[i].rd_addr1;
         bus.rd_addr2 = vecs[i].rd_addr2;
         bus.dbg_addr = vecs[i].dbg_addr;
         @(negedge clk);
         check($sformatf("vec%0d_rd1", i), bus.rd_data1, vecs[i].e_rd1);
         check($sformatf("vec%0d_rd2", i), bus.rd_data2, vecs[i].e_rd2);
         check($sformatf("vec%0d_dbg", i), bus.dbg_data, vecs[i].e_dbg);
         check($sformatf("vec%0d_drop", i), DW'(bus.wr_drop), DW'(vecs[i].e_drop));
         compare_all();
         edge_step();
      end
      set_idle();

      // Full sweep: load 1..31 with their index, clear, count busy/done cycles
      for (int a = 1; a < DEPTH; a++) write_reg(a, DW'(a));
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         bus.rd_addr1 = AW'(c);
         @(negedge clk);
         compare_all();
         if (bus.clr_busy) busy_cnt++;
         if (bus.clr_done) done_cnt++;
         edge_step();
      end
      check("sweep_busy_cycles", DW'(busy_cnt), DW'(32));
      check("sweep_done_pulses", DW'(done_cnt), DW'(1));
      for (int a = 0; a < DEPTH; a++) begin
         bus.rd_addr1 = AW'(a);
         bus.rd_addr2 = AW'(DEPTH - 1 - a);
         @(negedge clk);
         check($sformatf("cleared_r%0d", a), bus.rd_data1, '0);
         check($sformatf("cleared_r%0d", DEPTH - 1 - a), bus.rd_data2, '0);
         edge_step();
      end
      set_idle();

      // Mid-sweep write at pointer 10
      for (int a = 1; a < DEPTH; a++) write_reg(a, DW'(a));
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      bus.wr_en    = 1'b1;
      bus.wr_addr  = AW'(3);
      bus.wr_data  = 32'hAAAA;
      bus.rd_addr1 = AW'(20);
      bus.rd_addr2 = AW'(3);
      #3;
      check("mid_rd20_unswept", bus.rd_data1, 32'd20);
      check("mid_rd3_swept", bus.rd_data2, '0);
      check("mid_busy", DW'(bus.clr_busy), DW'(1));
      tick();
      bus.wr_en = 1'b0;
      #3;
      check("mid_wr_drop", DW'(bus.wr_drop), DW'(1));
      check("mid_rd3_after", bus.rd_data2, '0);
      check("mid_rd20_still", bus.rd_data1, 32'd20);
      for (int c = 0; c < 30; c++) tick();
      set_idle();

      // Reset asserted mid-sweep aborts without a done pulse
      write_reg(7, 32'h77);
      bus.clr_req = 1'b1;
      tick();
      bus.clr_req = 1'b0;
      for (int c = 0; c < 5; c++) tick();
      bus.rd_addr1 = AW'(7);
      bus.rd_addr2 = AW'(30);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("abort_busy", DW'(bus.clr_busy), '0);
      check("abort_done", DW'(bus.clr_done), '0);
      check("abort_rd7", bus.rd_data1, '0);
      check("abort_rd30", bus.rd_data2, '0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      done_cnt = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         compare_all();
         if (bus.clr_done) done_cnt++;
         edge_step();
      end
      check("abort_no_done", DW'(done_cnt), '0);

      // Randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         bus.wr_en    = $urandom_range(0, 1) == 1;
         bus.wr_addr  = AW'($urandom_range(0, DEPTH - 1));
         bus.wr_data  = DW'($urandom);
         bus.clr_req  = $urandom_range(0, 40) == 0;
         bus.rd_addr1 = AW'($urandom_range(0, DEPTH - 1));
         bus.rd_addr2 = ($urandom_range(0, 3) == 0) ? bus.wr_addr : AW'($urandom_range(0, DEPTH - 1));
         bus.dbg_addr = AW'($urandom_range(0, DEPTH - 1));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised general-purpose register file for the MIPS CPU datapath.
- Provides two combinational read ports, one synchronous write port, and a hardwired zero register.
- Adds a sequential soft-clear engine that sweeps every register to zero without asserting reset.
- Adds a registered debug read port that replaces per-register output taps; the top-level display logic uses it to scan registers.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is an ordinary register.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_addr1  in  ADDR_W  read port 1 address.
- rd_data1  out  DATA_W  read port 1 data, combinational.
- rd_addr2  in  ADDR_W  read port 2 address.
- rd_data2  out  DATA_W  read port 2 data, combinational.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  soft-clear request, sampled on the rising edge.
- clr_busy  out  1  high while the clear sweep runs.
- clr_done  out  1  one-cycle pulse when the sweep completes.
- wr_drop  out  1  one-cycle pulse: the write in the previous cycle was discarded.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  registered debug read data.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all registers = 0;
  - FSM = IDLE, clear pointer = 0;
  - clr_busy=0, clr_done=0, wr_drop=0, dbg_data=0.
  - Reset asserted mid-sweep aborts the sweep immediately; no clr_done pulse.
- Write:
  - On a rising edge with wr_en=1 and FSM=IDLE, register[wr_addr] <= wr_data.
  - A write to address 0 is ignored when ZERO_REG=1; wr_drop is not asserted for it.
- Read:
  - rd_dataN = register[rd_addrN], combinational.
  - Returns 0 for address 0 when ZERO_REG=1.
  - Both ports may read the same address simultaneously.
- Debug port:
  - dbg_data <= register[dbg_addr] each rising edge (1-cycle latency).
  - ZERO_REG masking applies.
  - The captured value is the pre-edge contents; a same-edge write is not visible.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP: on clr_req=1; pointer = 0; clr_busy goes high the following cycle.
  - SWEEP: each cycle, register[pointer] <= 0 and pointer += 1. When pointer = DEPTH-1, that register is cleared and the FSM moves to DONE. The sweep takes exactly DEPTH cycles.
  - DONE: clr_done=1 for one cycle, clr_busy=0, then IDLE.
  - clr_req while in SWEEP or DONE is ignored; requests are not queued.
- Writes during SWEEP or DONE:
  - The write is discarded.
  - wr_drop=1 in the following cycle.
  - When wr_en=1 on consecutive cycles, wr_drop stays high continuously.
- Reads during SWEEP return the current contents: already-swept registers read 0, the rest keep their old values.
- clr_req and wr_en in the same IDLE cycle: the write commits on that edge and the sweep starts. The written register is cleared when the pointer reaches it.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding.
  - If wr_en=1, FSM=IDLE, wr_addr == rd_addrN, and the address is not a zero register, then rd_dataN = wr_data combinationally in the same cycle.
  - Forwarding applies independently to each port.
  - dbg_data is not bypassed.
- Undefined: rd_dataN shows the old value until after the write edge.

Test Plan:
- Reset, then write 0xDEADBEEF to reg 8, read rd_addr1=8 next cycle -> rd_data1=0xDEADBEEF; rd_addr2=9 -> 0.
- ZERO_REG=1: write 0x12345678 to reg 0 -> rd_data1 = 0 and wr_drop stays 0.
- Write regs 1..31 with value = index; pulse clr_req -> clr_busy high for 32 cycles, clr_done pulses once, then all registers read 0.
- Mid-sweep at pointer 10: write 0xAAAA to reg 3 -> wr_drop=1 next cycle; reg 3 = 0; reg 20 still reads 20 until swept.
- Mid-sweep: drop rst_n -> clr_busy=0 immediately, all registers 0, no clr_done pulse.
- REGFILE_BYPASS_EN defined: wr_en=1, wr_addr=5, wr_data=0x55, rd_addr1=rd_addr2=5 in the same cycle -> both rd_data=0x55. Undefined -> old value before the edge, 0x55 after. dbg_addr=5 -> dbg_data=0x55 one cycle after the commit.
